hold_release_detector: RTL



---
 rtl/hold_release_detector.sv | 146 ++++++++++++++
 1 files changed

// File: rtl/hold_release_detector.sv
// hold_release_detector: debounces the active-low hold push-button and turns
// accepted presses/releases into single-cycle hold_tick / release_tick pulses
// plus a hold_state level for LEDs and display logic.
//
// Build option: define HOLD_TOGGLE_EN for toggle mode (each accepted press
// alternates hold/release, button releases emit nothing). Left undefined, the
// block runs in momentary mode (press -> hold_tick, release -> release_tick).
//
// state   | meaning
// --------+-------------------------------------------------------------
// REL     | debounced released, waiting for key_s to go low
// REL_CHK | key_s low, counting stable cycles toward an accepted press
// PRS     | debounced pressed, waiting for key_s to go high
// PRS_CHK | key_s high, counting stable cycles toward an accepted release
module hold_release_detector #(
    parameter int DEBOUNCE_CYCLES = 250000,
    parameter int CNT_W           = 18
) (
    input  logic clk,
    input  logic rst,
    input  logic key_n,
    output logic hold_tick,
    output logic release_tick,
    output logic hold_state
);

    typedef enum logic [1:0] {
        REL     = 2'd0,
        REL_CHK = 2'd1,
        PRS     = 2'd2,
        PRS_CHK = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0] TERM_CNT = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             key_meta;
    logic             key_s;
    state_t           state_q;
    state_t           state_d;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic             hold_d;
    logic             release_d;
    logic             hold_state_d;

    // Two-flop synchronizer; resets to the released level so a held key
    // after reset is seen as a fresh press.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            key_meta <= 1'b1;
            key_s    <= 1'b1;
        end else begin
            key_meta <= key_n;
            key_s    <= key_meta;
        end
    end

    // Debounce state, stability counter and registered tick outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= REL;
            cnt_q        <= '0;
            hold_tick    <= 1'b0;
            release_tick <= 1'b0;
            hold_state   <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            hold_tick    <= hold_d;
            release_tick <= release_d;
            hold_state   <= hold_state_d;
        end
    end

    // Next state, counter and tick decode; the counter is cleared on every
    // state change so the terminal count always forces an exit before wrap.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        hold_d    = 1'b0;
        release_d = 1'b0;
        case (state_q)
            REL: begin
                if (!key_s) begin
                    state_d = REL_CHK;
                    cnt_d   = '0;
                end
            end
            REL_CHK: begin
                if (key_s) begin
                    state_d = REL;
                    cnt_d   = '0;
                end else if (cnt_q == TERM_CNT) begin
                    state_d = PRS;
                    cnt_d   = '0;
`ifdef HOLD_TOGGLE_EN
                    if (hold_state) begin
                        release_d = 1'b1;
                    end else begin
                        hold_d = 1'b1;
                    end
`else
                    hold_d = 1'b1;
`endif
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            PRS: begin
                if (key_s) begin
                    state_d = PRS_CHK;
                    cnt_d   = '0;
                end
            end
            PRS_CHK: begin
                if (!key_s) begin
                    state_d = PRS;
                    cnt_d   = '0;
                end else if (cnt_q == TERM_CNT) begin
                    state_d = REL;
                    cnt_d   = '0;
`ifndef HOLD_TOGGLE_EN
                    release_d = 1'b1;
`endif
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = REL;
                cnt_d   = '0;
            end
        endcase
    end

    // hold_state follows the ticks in the same cycle they are issued.
    always_comb begin
        hold_state_d = hold_state;
        if (hold_d) begin
            hold_state_d = 1'b1;
        end else if (release_d) begin
            hold_state_d = 1'b0;
        end
    end

endmodule
